// File: rtl/instr_decode_stage.sv
// RV32I decode stage: decodes fetch words into a DEPTH-entry queue; outputs valid one cycle after accept.
// Backpressure: in_ready depends only on occupancy and rst, never on out_ready (no through-path).

// Generic circular-buffer FIFO with synchronous clear; rd_dat shows the head entry.
module fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         push,
  input  logic                         pop,
  input  logic [W-1:0]                 wr_dat,
  output logic [W-1:0]                 rd_dat,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !(rst || clr)) mem[wptr] <= wr_dat;
  end

  assign rd_dat = mem[rptr];
endmodule

module instr_decode_stage #(
  parameter int XLEN  = 32,
  parameter int PC_W  = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_instr,
  input  logic [PC_W-1:0]            in_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PC_W-1:0]            out_pc,
  output logic [6:0]                 out_opcode,
  output logic [2:0]                 out_func3,
  output logic [6:0]                 out_func7,
  output logic [4:0]                 out_rs1,
  output logic [4:0]                 out_rs2,
  output logic [4:0]                 out_rd,
  output logic [XLEN-1:0]            out_imm,
  output logic                       out_illegal,
  output logic [$clog2(DEPTH+1)-1:0] out_count
);
  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [6:0]      opcode;
    logic [2:0]      func3;
    logic [6:0]      func7;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic            illegal;
  } dec_t;

  dec_t        dec_dat;
  dec_t        head_dat;
  dec_t        out_dat;
  logic [31:0] imm32;
  logic        push_vld;
  logic        pop_vld;
  logic        full;
  logic        empty;

  always_comb begin
    imm32           = '0;
    dec_dat         = '0;
    dec_dat.pc      = in_pc;
    dec_dat.opcode  = in_instr[6:0];
    dec_dat.rd      = in_instr[11:7];
    dec_dat.func3   = in_instr[14:12];
    dec_dat.rs1     = in_instr[19:15];
    dec_dat.rs2     = in_instr[24:20];
    dec_dat.func7   = in_instr[31:25];
    dec_dat.illegal = 1'b0;
    case (in_instr[6:0])
      7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011:
        imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      7'b0100011:
        imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      7'b1100011:
        imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                 in_instr[11:8], 1'b0};
      7'b0110111, 7'b0010111:
        imm32 = {in_instr[31:12], 12'b0};
      7'b1101111:
        imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                 in_instr[30:21], 1'b0};
      7'b0110011:
        imm32 = '0;
      default:
        dec_dat.illegal = 1'b1;
    endcase
    dec_dat.imm = {{(XLEN-31){imm32[31]}}, imm32[30:0]};
  end

  assign in_ready  = ~full & ~rst;
  assign out_valid = ~empty;
  assign push_vld  = in_valid & in_ready;
  assign pop_vld   = out_valid & out_ready;

  fifo #(
    .W     ($bits(dec_t)),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk    (clk),
    .rst    (rst),
    .clr    (flush),
    .push   (push_vld),
    .pop    (pop_vld),
    .wr_dat (dec_dat),
    .rd_dat (head_dat),
    .count  (out_count),
    .full   (full),
    .empty  (empty)
  );

  // Stale storage must never leak onto the outputs while the queue is empty.
  assign out_dat     = out_valid ? head_dat : '0;
  assign out_pc      = out_dat.pc;
  assign out_opcode  = out_dat.opcode;
  assign out_func3   = out_dat.func3;
  assign out_func7   = out_dat.func7;
  assign out_rs1     = out_dat.rs1;
  assign out_rs2     = out_dat.rs2;
  assign out_rd      = out_dat.rd;
  assign out_imm     = out_dat.imm;
  assign out_illegal = out_dat.illegal;
endmodule

// File: tb/tb_instr_decode_stage.sv
// Bench for instr_decode_stage: directed steps then random traffic against a queue-based reference model.
module tb_instr_decode_stage;
  localparam int XLEN  = 32;
  localparam int PC_W  = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);

  logic            clk = 1'b0;
  logic            rst, flush, in_valid, out_ready;
  logic            in_ready, out_valid, out_illegal;
  logic [31:0]     in_instr;
  logic [PC_W-1:0] in_pc, out_pc;
  logic [6:0]      out_opcode, out_func7;
  logic [2:0]      out_func3;
  logic [4:0]      out_rs1, out_rs2, out_rd;
  logic [XLEN-1:0] out_imm;
  logic [CW-1:0]   out_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0]     instr;
    logic [PC_W-1:0] pc;
  } ent_t;
  ent_t q[$];

  always #5 clk = ~clk;

  instr_decode_stage #(.XLEN(XLEN), .PC_W(PC_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_opcode(out_opcode), .out_func3(out_func3), .out_func7(out_func7),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_imm(out_imm), .out_illegal(out_illegal), .out_count(out_count)
  );

  function automatic bit is_legal(logic [6:0] op);
    return op inside {7'h03, 7'h13, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};
  endfunction

  // Immediate as a signed integer sum of weighted instruction bits.
  function automatic logic [31:0] ref_imm(logic [31:0] w);
    int v;
    int s;
    s = w[31] ? 1 : 0;
    case (w[6:0])
      7'h03, 7'h13, 7'h67, 7'h73: v = -2048*s + int'(w[30:20]);
      7'h23: v = -2048*s + int'(w[30:25])*32 + int'(w[11:7]);
      7'h63: v = -4096*s + int'(w[7])*2048 + int'(w[30:25])*32 + int'(w[11:8])*2;
      7'h37, 7'h17: v = int'(w & 32'hFFFF_F000);
      7'h6F: v = -(1 << 20)*s + int'(w[19:12])*4096 + int'(w[20])*2048 + int'(w[30:21])*2;
      default: v = 0;
    endcase
    return 32'(v);
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    ent_t        e;
    logic [31:0] w;
    bit          v;
    v = (q.size() != 0);
    if (v) e = q[0];
    else begin
      e.instr = '0;
      e.pc    = '0;
    end
    w = e.instr;
    chk("in_ready",    in_ready,   64'(!rst && q.size() < DEPTH));
    chk("out_valid",   out_valid,  64'(v));
    chk("out_count",   out_count,  64'(q.size()));
    chk("out_pc",      out_pc,     e.pc);
    chk("out_opcode",  out_opcode, w[6:0]);
    chk("out_rd",      out_rd,     w[11:7]);
    chk("out_func3",   out_func3,  w[14:12]);
    chk("out_rs1",     out_rs1,    w[19:15]);
    chk("out_rs2",     out_rs2,    w[24:20]);
    chk("out_func7",   out_func7,  w[31:25]);
    chk("out_imm",     out_imm,    v ? ref_imm(w) : 32'h0);
    chk("out_illegal", out_illegal, 64'(v && !is_legal(w[6:0])));
  endtask

  // One clock: drive, check current state, advance the model, cross the edge.
  task automatic cyc(bit r, bit f, bit iv, logic [31:0] w, logic [PC_W-1:0] pc, bit ordy);
    bit push;
    bit pop;
    rst = r; flush = f; in_valid = iv; in_instr = w; in_pc = pc; out_ready = ordy;
    #1;
    check_state();
    push = !r && iv && (q.size() < DEPTH);
    pop  = (q.size() != 0) && ordy;
    if (r || f) q.delete();
    else begin
      if (pop) q.delete(0);
      if (push) q.push_back('{w, pc});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [6:0]  ops [12];
    logic [31:0] w;
    ops = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h0F, 7'h7F};
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_instr = 32'h0050_0093;
    in_pc = 32'h100; out_ready = 1'b0;
    @(posedge clk);
    #1;

    // reset with in_valid held high
    cyc(1, 0, 1, 32'h0050_0093, 32'h100, 0);
    cyc(1, 0, 1, 32'h0050_0093, 32'h104, 0);
    chk("rst_count", out_count, 0);
    cyc(0, 0, 0, 32'h0, 32'h0, 1);

    // addi x1,x0,5
    cyc(0, 0, 1, 32'h0050_0093, 32'h200, 1);
    chk("addi_valid", out_valid, 1);
    chk("addi_op", out_opcode, 7'h13);
    chk("addi_rd", out_rd, 1);
    chk("addi_imm", out_imm, 32'd5);
    chk("addi_ill", out_illegal, 0);
    cyc(0, 0, 0, 32'h0, 32'h0, 1);
    chk("addi_drained", out_valid, 0);

    // sw then beq back to back
    cyc(0, 0, 1, 32'hFE20_AE23, 32'h300, 1);
    chk("sw_imm", out_imm, 32'hFFFF_FFFC);
    chk("sw_rs1", out_rs1, 1);
    chk("sw_rs2", out_rs2, 2);
    cyc(0, 0, 1, 32'hFE00_0CE3, 32'h304, 1);
    chk("beq_imm", out_imm, 32'hFFFF_FFF8);
    cyc(0, 0, 0, 32'h0, 32'h0, 1);

    // backpressure: DEPTH+1 offers, then drain across pointer wrap
    for (int i = 0; i <= DEPTH; i++)
      cyc(0, 0, 1, 32'h0000_0013 | (32'(i) << 20), 32'h400 + 32'(4*i), 0);
    chk("bp_count", out_count, DEPTH);
    chk("bp_ready", in_ready, 0);
    for (int i = 0; i < DEPTH; i++) begin
      chk("bp_order_pc", out_pc, 32'h400 + 32'(4*i));
      cyc(0, 0, 0, 32'h0, 32'h0, 1);
    end

    // flush with two queued, concurrent push and pop
    cyc(0, 0, 1, 32'h0010_0093, 32'h500, 0);
    cyc(0, 0, 1, 32'h0020_0093, 32'h504, 0);
    chk("pre_flush_count", out_count, 2);
    cyc(0, 1, 1, 32'h0030_0093, 32'h508, 1);
    chk("flush_count", out_count, 0);
    chk("flush_valid", out_valid, 0);
    chk("flush_ready", in_ready, 1);

    // illegal opcode then a legal one
    cyc(0, 0, 1, 32'h0000_007F, 32'h600, 1);
    chk("ill_flag", out_illegal, 1);
    chk("ill_imm", out_imm, 0);
    chk("ill_op", out_opcode, 7'h7F);
    cyc(0, 0, 1, 32'h0050_0093, 32'h604, 1);
    chk("post_ill_flag", out_illegal, 0);
    chk("post_ill_imm", out_imm, 32'd5);
    cyc(0, 0, 0, 32'h0, 32'h0, 1);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      w = $urandom();
      w[6:0] = ops[$urandom_range(0, 11)];
      cyc(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 5),
          ($urandom_range(0, 99) < 70), w, PC_W'($urandom()),
          ($urandom_range(0, 99) < 55));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
